// File: rtl/rng_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : rng_pkg                                                      |
// | Description : Shared constants, types and helpers for the 96-bit LFSR      |
// |               random source (register width, feedback taps, lockup-free    |
// |               default seed, FSM encoding, counter sizing).                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package rng_pkg;

  // Register width and feedback taps for x^96 + x^94 + x^49 + x^47 + 1.
  localparam int LFSR_W = 96;
  localparam int TAP_0  = 95;
  localparam int TAP_1  = 93;
  localparam int TAP_2  = 48;
  localparam int TAP_3  = 46;

  // The all-zero state is a fixed point of the LFSR, so this value stands in
  // whenever a zero seed is supplied and also serves as the reset state.
  localparam logic [LFSR_W-1:0] SEED_DEFAULT = 96'h1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } rng_state_t;

  // Width of a counter that must hold 0 .. cycles-1. Never below one bit so
  // that the single-cycle configuration still has a legal counter.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

  // Replace a zero seed with the lockup-free default.
  function automatic logic [LFSR_W-1:0] seed_or_default(input logic [LFSR_W-1:0] seed);
    return (seed == '0) ? SEED_DEFAULT : seed;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr96_advance.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lfsr96_advance                                               |
// | Description : Purely combinational STEP-fold unrolling of the 96-bit       |
// |               Fibonacci LFSR bit-step.                                     |
// | Revision    : 1.0 - initial release                                        |
// |                                                                            |
// | Ports                                                                      |
// |   state_in   in  96  current LFSR state                                    |
// |   state_out  out 96  state after STEP chained bit-steps                    |
// +----------------------------------------------------------------------------+
module lfsr96_advance
  import rng_pkg::*;
#(
  parameter int STEP = 8
) (
  input  logic [LFSR_W-1:0] state_in,
  output logic [LFSR_W-1:0] state_out
);

  // chain[i] is the state after i bit-steps; each stage feeds the next.
  logic [LFSR_W-1:0] chain [0:STEP];

  assign chain[0] = state_in;

  for (genvar i = 0; i < STEP; i++) begin : g_step
    assign chain[i+1] = {chain[i][LFSR_W-2:0],
                         chain[i][TAP_0] ^ chain[i][TAP_1] ^
                         chain[i][TAP_2] ^ chain[i][TAP_3]};
  end

  assign state_out = chain[STEP];

endmodule
`default_nettype wire

// File: rtl/rng_lfsr96.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rng_lfsr96                                                   |
// | Description : Request/finish pseudo-random source. Each accepted request   |
// |               optionally reseeds the 96-bit LFSR, advances it by 96        |
// |               bit-steps (STEP per clock) and publishes the new state with  |
// |               a one-cycle finish pulse.                                    |
// | Revision    : 1.0 - initial release                                        |
// |                                                                            |
// | Parameters                                                                 |
// |   STEP        bit-steps per clock; must divide 96                          |
// | Ports                                                                      |
// |   clk         in  1   clock, rising edge                                   |
// |   rst_b       in  1   asynchronous active-low reset                        |
// |   rng_start   in  1   request, sampled only in IDLE                        |
// |   rng_in_mod  in  1   reseed qualifier, sampled with rng_start             |
// |   rng_seed    in  96  seed, used when rng_in_mod=1 at acceptance           |
// |   rng_data    out 96  registered result, held between finishes            |
// |   rng_finish  out 1   one-cycle pulse, rng_data valid                      |
// |   rng_busy    out 1   high while in RUN or DONE                            |
// +----------------------------------------------------------------------------+
module rng_lfsr96
  import rng_pkg::*;
#(
  parameter int STEP = 8
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              rng_start,
  input  logic              rng_in_mod,
  input  logic [LFSR_W-1:0] rng_seed,
  output logic [LFSR_W-1:0] rng_data,
  output logic              rng_finish,
  output logic              rng_busy
);

  // STEP is expected to divide LFSR_W exactly; otherwise the run would not
  // total 96 bit-steps.
  localparam int              RUN_CYCLES = LFSR_W / STEP;
  localparam int              CNT_W      = cnt_width(RUN_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(RUN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  rng_state_t        state_q, state_d;
  logic [LFSR_W-1:0] s_q, s_d;
  logic [LFSR_W-1:0] s_adv;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LFSR_W-1:0] data_d;
  logic              finish_d;
  logic              busy_d;

  lfsr96_advance #(
    .STEP (STEP)
  ) u_advance (
    .state_in  (s_q),
    .state_out (s_adv)
  );

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= ST_IDLE;
      s_q        <= SEED_DEFAULT;
      cnt_q      <= '0;
      rng_data   <= '0;
      rng_finish <= 1'b0;
      rng_busy   <= 1'b0;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      cnt_q      <= cnt_d;
      rng_data   <= data_d;
      rng_finish <= finish_d;
      rng_busy   <= busy_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state / datapath logic
  // -------------------------------------------------------------------------
  // finish and busy are computed one cycle ahead so both leave the block
  // straight from flops; finish is raised on the RUN->DONE edge and therefore
  // is high exactly for the DONE cycle.
  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    cnt_d    = cnt_q;
    data_d   = rng_data;
    finish_d = 1'b0;
    busy_d   = rng_busy;

    case (state_q)
      ST_IDLE: begin
        if (rng_start) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          busy_d  = 1'b1;
          // Without a reseed the LFSR simply continues from where the
          // previous request left it.
          if (rng_in_mod) begin
            s_d = seed_or_default(rng_seed);
          end
        end
      end

      ST_RUN: begin
        s_d = s_adv;
        if (cnt_q == CNT_LAST) begin
          state_d  = ST_DONE;
          cnt_d    = '0;
          data_d   = s_adv;
          finish_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_DONE: begin
        // rng_start is deliberately not examined here; a held request is
        // taken on the following IDLE cycle.
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_rng_lfsr96.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_rng_lfsr96                                                |
// | Description : Self-checking bench for rng_lfsr96 (STEP=8).                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_rng_lfsr96;
  import rng_pkg::*;

  localparam int STEP   = 8;
  localparam int LAT    = LFSR_W / STEP + 1;  // start edge to finish cycle
  localparam int PERIOD = LFSR_W / STEP + 2;  // back-to-back result spacing
  localparam logic [95:0] K_SEED1 = 96'h0000_0000_0002_8000_0000_0001;

  logic        clk;
  logic        rst_b;
  logic        rng_start;
  logic        rng_in_mod;
  logic [95:0] rng_seed;
  logic [95:0] rng_data;
  logic        rng_finish;
  logic        rng_busy;

  int checks = 0;
  int errors = 0;

  rng_lfsr96 #(
    .STEP (STEP)
  ) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .rng_start  (rng_start),
    .rng_in_mod (rng_in_mod),
    .rng_seed   (rng_seed),
    .rng_data   (rng_data),
    .rng_finish (rng_finish),
    .rng_busy   (rng_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        in_mod;
    logic [95:0] seed;
    logic [95:0] exp_data;
  } vec_t;

  vec_t vecs [5];

  // Bit-serial reference: 96 single steps of the Fibonacci register.
  function automatic logic [95:0] model_adv(input logic [95:0] s_in);
    logic [95:0] s;
    logic        fb;
    s = s_in;
    for (int i = 0; i < 96; i++) begin
      fb = s[TAP_0] ^ s[TAP_1] ^ s[TAP_2] ^ s[TAP_3];
      s  = {s[94:0], fb};
    end
    return s;
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request, then watch it through to the finish pulse.
  task automatic do_request(input logic in_mod, input logic [95:0] seed,
                            input logic [95:0] exp, input int idx);
    logic [95:0] prev;
    int          lat;
    bit          stable;
    bit          busy_ok;
    prev    = rng_data;
    lat     = 0;
    stable  = 1'b1;
    busy_ok = 1'b1;
    @(posedge clk); #1;
    rng_start  = 1'b1;
    rng_in_mod = in_mod;
    rng_seed   = seed;
    @(posedge clk); #1;                      // accepted on this edge
    rng_start  = 1'b0;
    for (int c = 1; c <= LAT + 6; c++) begin
      @(negedge clk);
      if (rng_finish) begin
        lat = c;
        if (rng_busy !== 1'b1) busy_ok = 1'b0;
        break;
      end
      if (rng_data !== prev) stable = 1'b0;
      if (rng_busy !== 1'b1) busy_ok = 1'b0;
      // qualifiers must be ignored while the request is in flight
      rng_in_mod = 1'($urandom_range(0, 1));
      rng_seed   = {$urandom(), $urandom(), $urandom()};
    end
    rng_in_mod = 1'b0;
    check($sformatf("vec%0d latency", idx), 96'(lat), 96'(LAT));
    check($sformatf("vec%0d data", idx), rng_data, exp);
    check($sformatf("vec%0d data_stable_in_run", idx), 96'(stable), 96'(1));
    check($sformatf("vec%0d busy_in_run_done", idx), 96'(busy_ok), 96'(1));
    @(negedge clk);
    check($sformatf("vec%0d finish_width", idx), 96'(rng_finish), 96'(0));
    check($sformatf("vec%0d busy_idle", idx), 96'(rng_busy), 96'(0));
    check($sformatf("vec%0d data_held", idx), rng_data, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [95:0] hh_exp [3];
    int          pc [3];
    int          pulses;
    int          hold;
    bit          saw_finish;
    bit          idle_ok;

    // ---------------- vector table ----------------
    vecs[0] = '{in_mod: 1'b1, seed: 96'h1,                         exp_data: K_SEED1};
    vecs[1] = '{in_mod: 1'b1, seed: 96'h0,                         exp_data: K_SEED1};
    vecs[2] = '{in_mod: 1'b1, seed: 96'h0000_0000_0000_0000_FFFF_FFFF,
                exp_data: model_adv(96'h0000_0000_0000_0000_FFFF_FFFF)};
    vecs[3] = '{in_mod: 1'b0, seed: 96'hDEAD_BEEF_0123_4567_89AB_CDEF,
                exp_data: model_adv(vecs[2].exp_data)};
    vecs[4] = '{in_mod: 1'b0, seed: 96'h0,                         exp_data: model_adv(vecs[3].exp_data)};

    // ---------------- reset and idle ----------------
    rst_b      = 1'b0;
    rng_start  = 1'b0;
    rng_in_mod = 1'b0;
    rng_seed   = '0;
    #1;
    check("reset data", rng_data, 96'h0);
    check("reset finish", 96'(rng_finish), 96'(0));
    check("reset busy", 96'(rng_busy), 96'(0));
    repeat (3) @(posedge clk);
    #1 rst_b = 1'b1;
    saw_finish = 1'b0;
    idle_ok    = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (rng_finish) saw_finish = 1'b1;
      if (rng_busy !== 1'b0 || rng_data !== 96'h0) idle_ok = 1'b0;
    end
    check("idle no_finish", 96'(saw_finish), 96'(0));
    check("idle outputs_quiet", 96'(idle_ok), 96'(1));

    // ---------------- table-driven requests ----------------
    for (int v = 0; v < 5; v++) begin
      do_request(vecs[v].in_mod, vecs[v].seed, vecs[v].exp_data, v);
      repeat (2) @(negedge clk);
    end

    // ---------------- rng_start held high ----------------
    hh_exp[0] = K_SEED1;
    hh_exp[1] = model_adv(hh_exp[0]);
    hh_exp[2] = model_adv(hh_exp[1]);
    pc[0] = 0; pc[1] = 0; pc[2] = 0;
    pulses = 0;
    hold   = 0;
    @(posedge clk); #1;
    rng_start  = 1'b1;
    rng_in_mod = 1'b1;
    rng_seed   = 96'h1;
    @(posedge clk); #1;                      // first acceptance
    for (int c = 1; c <= 3 * PERIOD + 6 && pulses < 3; c++) begin
      @(negedge clk);
      if (rng_finish) begin
        pc[pulses] = c;
        check($sformatf("held pulse%0d data", pulses), rng_data, hh_exp[pulses]);
        pulses++;
        rng_in_mod = 1'b0;                   // next acceptance continues the state
        hold = 2;
        if (pulses == 3) rng_start = 1'b0;
      end else if (hold > 0) begin
        hold--;
      end else begin
        rng_in_mod = 1'($urandom_range(0, 1));
        rng_seed   = {$urandom(), $urandom(), $urandom()};
      end
    end
    rng_start  = 1'b0;
    rng_in_mod = 1'b0;
    check("held pulse_count", 96'(pulses), 96'(3));
    check("held pulse0 cycle", 96'(pc[0]), 96'(LAT));
    check("held pulse1 cycle", 96'(pc[1]), 96'(LAT + PERIOD));
    check("held pulse2 cycle", 96'(pc[2]), 96'(LAT + 2 * PERIOD));
    repeat (3) @(negedge clk);

    // ---------------- reset in the middle of RUN ----------------
    @(posedge clk); #1;
    rng_start  = 1'b1;
    rng_in_mod = 1'b1;
    rng_seed   = 96'h0000_0000_0000_0000_FFFF_FFFF;
    @(posedge clk); #1;
    rng_start  = 1'b0;
    rng_in_mod = 1'b0;
    repeat (5) @(negedge clk);               // RUN cycle 5
    rst_b = 1'b0;
    #1;
    check("midrun_reset data", rng_data, 96'h0);
    check("midrun_reset busy", 96'(rng_busy), 96'(0));
    check("midrun_reset finish", 96'(rng_finish), 96'(0));
    saw_finish = 1'b0;
    repeat (LAT) begin
      @(negedge clk);
      if (rng_finish) saw_finish = 1'b1;
    end
    check("midrun_reset no_finish", 96'(saw_finish), 96'(0));
    @(posedge clk); #1 rst_b = 1'b1;
    do_request(1'b0, 96'h1234_5678_9ABC_DEF0_1357_9BDF, K_SEED1, 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
